uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, LCR field layout,
// parity-mode encodings and the layout of one received-character entry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // LCR bit positions
  localparam int LCR_WLEN_LSB  = 0;
  localparam int LCR_WLEN_MSB  = 1;
  localparam int LCR_STOP2     = 2;
  localparam int LCR_PEN       = 3;
  localparam int LCR_PMODE_LSB = 3;
  localparam int LCR_PMODE_MSB = 5;

  // LCR[5:3] parity modes (bit 3 is the enable, so all valid modes are odd codes)
  localparam logic [2:0] PAR_ODD    = 3'b001;
  localparam logic [2:0] PAR_EVEN   = 3'b011;
  localparam logic [2:0] PAR_STICK1 = 3'b101;
  localparam logic [2:0] PAR_STICK0 = 3'b111;

  localparam int         ENTRY_W    = 11;
  localparam int         FIFO_AW    = 4;
  localparam int         FIFO_DEPTH = 16;
  localparam logic [4:0] FIFO_FULL_CNT = 5'd16;

  typedef struct packed {
    logic       brk;
    logic       framing_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  // Value the parity bit must carry for the given mode and received data.
  function automatic logic expected_parity(input logic [2:0] mode,
                                           input logic [7:0] data);
    logic exp_bit;
    case (mode)
      PAR_ODD:    exp_bit = ~^data;
      PAR_EVEN:   exp_bit = ^data;
      PAR_STICK1: exp_bit = 1'b1;
      default:    exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 16-entry receive FIFO holding {break, framing_err, parity_err, data} words.
// Head entry is presented combinationally; pop on empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] data_in,
  output logic [ENTRY_W-1:0] data_out,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [4:0]         count
);

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [4:0]         r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign fifo_empty = (r_count == 5'd0);
  assign fifo_full  = (r_count == FIFO_FULL_CNT);
  assign count      = r_count;

  assign w_do_pop  = pop && !fifo_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_do_push = push && (!fifo_full || w_do_pop);

  // NOTE: the storage array has no reset; the output is forced to zero while
  // empty so stale contents are never visible after reset.
  assign data_out = fifo_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled framing FSM with parity/framing/break
// detection, feeding a 16-entry receive FIFO with overrun signalling.
module uart_rx
  import uart_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                RXD,
  input  logic                enable,
  input  logic [7:0]          LCR,
  input  logic                rx_fifo_pop,
  output logic [ENTRY_W-1:0]  rx_fifo_out,
  output logic                rx_fifo_empty,
  output logic                rx_fifo_full,
  output logic [4:0]          rx_fifo_count,
  output logic                overrun,
  output logic                busy
);

  logic      r_rxd_meta;
  logic      r_rxd_s;
  rx_state_e r_state,    w_state_nxt;
  logic [3:0] r_tick,    w_tick_nxt;
  logic [2:0] r_idx,     w_idx_nxt;
  logic [7:0] r_data,    w_data_nxt;
  logic      r_par_bit,  w_par_bit_nxt;
  logic      r_par_err,  w_par_err_nxt;
  rx_entry_t r_entry,    w_entry_nxt;
  logic      r_push_req, w_push_nxt;

  logic [1:0] w_wlen;
  logic       w_pen;
  logic [2:0] w_pmode;
  logic [2:0] w_last_idx;
  logic       w_unused_lcr;

  assign w_wlen       = LCR[LCR_WLEN_MSB:LCR_WLEN_LSB];
  assign w_pen        = LCR[LCR_PEN];
  assign w_pmode      = LCR[LCR_PMODE_MSB:LCR_PMODE_LSB];
  assign w_last_idx   = {1'b0, w_wlen} + 3'd4;
  assign w_unused_lcr = ^{LCR[7:6], LCR[LCR_STOP2]};

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_par_bit  <= 1'b0;
      r_par_err  <= 1'b0;
      r_entry    <= '0;
      r_push_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_par_err  <= w_par_err_nxt;
      r_entry    <= w_entry_nxt;
      r_push_req <= w_push_nxt;
    end
  end

  // NOTE: every output of this block gets a hold/default value first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_data;
    w_par_bit_nxt = r_par_bit;
    w_par_err_nxt = r_par_err;
    w_entry_nxt   = r_entry;
    w_push_nxt    = 1'b0;

    if (enable) begin
      w_tick_nxt = r_tick + 4'd1;
      case (r_state)
        ST_IDLE: begin
          w_tick_nxt = '0;
          if (!r_rxd_s) w_state_nxt = ST_START;
        end

        // Re-check the line mid start bit to reject glitches.
        ST_START: begin
          if (r_tick == 4'd7) begin
            w_tick_nxt = '0;
            if (!r_rxd_s) begin
              w_state_nxt   = ST_DATA;
              w_idx_nxt     = '0;
              w_data_nxt    = '0;
              w_par_bit_nxt = 1'b0;
              w_par_err_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (r_tick == 4'd15) begin
            w_data_nxt[r_idx] = r_rxd_s;
            w_idx_nxt         = r_idx + 3'd1;
            if (r_idx == w_last_idx) begin
              w_state_nxt = w_pen ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (r_tick == 4'd15) begin
            w_par_bit_nxt = r_rxd_s;
            w_par_err_nxt = (r_rxd_s != expected_parity(w_pmode, r_data));
            w_state_nxt   = ST_STOP;
          end
        end

        // Stop sample builds the entry; the push happens on the next PCLK.
        ST_STOP: begin
          if (r_tick == 4'd15) begin
            w_entry_nxt.brk         = (r_data == 8'h00) && !(w_pen && r_par_bit)
                                      && !r_rxd_s;
            w_entry_nxt.framing_err = ~r_rxd_s;
            w_entry_nxt.parity_err  = r_par_err;
            w_entry_nxt.data        = r_data;
            w_push_nxt              = 1'b1;
            w_tick_nxt              = '0;
            w_state_nxt             = r_rxd_s ? ST_IDLE : ST_WAIT_HIGH;
          end
        end

        ST_WAIT_HIGH: begin
          w_tick_nxt = '0;
          if (r_rxd_s) w_state_nxt = ST_IDLE;
        end

        default: begin
          w_tick_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_push_req && rx_fifo_full && !rx_fifo_pop;

  uart_rx_fifo u_fifo (
    .clk        (PCLK),
    .rstn       (PRESETn),
    .push       (r_push_req),
    .pop        (rx_fifo_pop),
    .data_in    (r_entry),
    .data_out   (rx_fifo_out),
    .fifo_empty (rx_fifo_empty),
    .fifo_full  (rx_fifo_full),
    .count      (rx_fifo_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: framing, parity, break,
// false start, reset abort and FIFO overrun.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;  // 16 enable ticks x 4 PCLK per tick

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        RXD = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  LCR = 8'h00;
  logic        rx_fifo_pop = 1'b0;
  logic [10:0] rx_fifo_out;
  logic        rx_fifo_empty;
  logic        rx_fifo_full;
  logic [4:0]  rx_fifo_count;
  logic        overrun;
  logic        busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ovr_cnt = 0;
  int   div = 0;
  logic mid_busy = 1'b0;

  uart_rx dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .RXD           (RXD),
    .enable        (enable),
    .LCR           (LCR),
    .rx_fifo_pop   (rx_fifo_pop),
    .rx_fifo_out   (rx_fifo_out),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_count (rx_fifo_count),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    div    = (div + 1) % 4;
    enable = (div == 0);
  end

  always @(negedge PCLK) begin
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Leaves RXD at the stop-bit level when it returns.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                            input bit pbit, input bit stopb);
    RXD = 1'b0;
    wait_clks(BIT_CLKS / 2);
    mid_busy = busy;
    wait_clks(BIT_CLKS / 2);
    for (int i = 0; i < nbits; i++) begin
      RXD = d[i];
      wait_clks(BIT_CLKS);
    end
    if (pen) begin
      RXD = pbit;
      wait_clks(BIT_CLKS);
    end
    RXD = stopb;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pop_expect(input string tag, input logic [10:0] exp);
    check(tag, rx_fifo_out, exp);
    rx_fifo_pop = 1'b1;
    @(negedge PCLK);
    rx_fifo_pop = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    wait_clks(4);
    check("rst_empty", rx_fifo_empty, 1);
    check("rst_full",  rx_fifo_full, 0);
    check("rst_count", rx_fifo_count, 0);
    check("rst_out",   rx_fifo_out, 0);
    check("rst_busy",  busy, 0);
    check("rst_ovr",   overrun, 0);
    PRESETn = 1'b1;
    wait_clks(8);

    // 8N1 0xA5
    LCR = 8'h03;
    send_frame(8'hA5, 8, 0, 0, 1);
    check("a5_mid_busy", mid_busy, 1);
    check("a5_busy_end", busy, 0);
    check("a5_count",    rx_fifo_count, 1);
    pop_expect("a5_entry", 11'h0A5);
    check("a5_empty",    rx_fifo_empty, 1);

    // even parity, wrong parity bit
    LCR = 8'h1B;
    send_frame(8'h07, 8, 1, 0, 1);
    check("even_count", rx_fifo_count, 1);
    pop_expect("even_perr", 11'h107);

    // odd parity, correct parity bit
    LCR = 8'h0B;
    send_frame(8'h07, 8, 1, 0, 1);
    check("odd_count", rx_fifo_count, 1);
    pop_expect("odd_ok", 11'h007);

    // stick-1, data 0 with parity 1: no error and not a break
    LCR = 8'h2B;
    send_frame(8'h00, 8, 1, 1, 1);
    check("stk1_count", rx_fifo_count, 1);
    pop_expect("stk1_ok", 11'h000);

    // 5-bit frame with bad stop, line held low afterwards
    LCR = 8'h00;
    send_frame(8'h1F, 5, 0, 0, 0);
    wait_clks(BIT_CLKS * 2);
    check("fe_wait_busy", busy, 1);
    check("fe_count",     rx_fifo_count, 1);
    RXD = 1'b1;
    wait_clks(16);
    check("fe_idle", busy, 0);
    pop_expect("fe_entry", 11'h21F);

    // break: line low for 20 bit times
    LCR = 8'h03;
    RXD = 1'b0;
    wait_clks(BIT_CLKS * 20);
    RXD = 1'b1;
    wait_clks(BIT_CLKS);
    check("brk_count", rx_fifo_count, 1);
    pop_expect("brk_entry", 11'h600);
    check("brk_empty", rx_fifo_empty, 1);

    // false start: 4-tick low pulse
    RXD = 1'b0;
    wait_clks(16);
    RXD = 1'b1;
    check("fs_busy", busy, 1);
    wait_clks(BIT_CLKS);
    check("fs_idle",  busy, 0);
    check("fs_count", rx_fifo_count, 0);

    // reset mid-character
    RXD = 1'b0;
    wait_clks(BIT_CLKS * 3);
    PRESETn = 1'b0;
    @(negedge PCLK);
    RXD = 1'b1;
    check("rab_busy", busy, 0);
    wait_clks(3);
    PRESETn = 1'b1;
    wait_clks(BIT_CLKS * 12);
    check("rab_count", rx_fifo_count, 0);
    check("rab_idle",  busy, 0);

    // overrun: 17 characters, no pops
    ovr_cnt = 0;
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 8, 0, 0, 1);
    check("ovr_none_yet", ovr_cnt, 0);
    check("ovr_full16",   rx_fifo_full, 1);
    send_frame(8'h99, 8, 0, 0, 1);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_count",  rx_fifo_count, 16);
    check("ovr_full",   rx_fifo_full, 1);
    for (int i = 0; i < 16; i++) pop_expect($sformatf("ovr_rd%0d", i), {3'b000, 8'h40 + 8'(i)});
    check("ovr_empty", rx_fifo_empty, 1);
    check("ovr_cnt0",  rx_fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
